// File: rtl/reqrsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reqrsp_pkg
// Description : Request/response protocol types shared across the cluster.
//               Only the atomic-operation encoding is needed by the TCDM
//               bank slice.
// Revision    : 1.0  initial release
// ============================================================================
package reqrsp_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

endpackage
`default_nettype wire

// File: rtl/snitch_tcdm_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snitch_tcdm_bank_pkg
// Description : Types and helpers shared by the TCDM memory bank and its
//               atomic-operation ALU.
// Revision    : 1.0  initial release
// ============================================================================
package snitch_tcdm_bank_pkg;

    localparam int unsigned MaxLatency = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AMO_WR = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        W32_LO = 2'd0,
        W32_HI = 2'd1,
        W64    = 2'd2
    } amo_width_e;

    // Only the three aligned strobe patterns select an AMO width.
    function automatic logic strb_is_amo_width(input logic [7:0] strb);
        return (strb == 8'h0F) || (strb == 8'hF0) || (strb == 8'hFF);
    endfunction

    function automatic amo_width_e strb_to_amo_width(input logic [7:0] strb);
        amo_width_e w;
        case (strb)
            8'h0F:   w = W32_LO;
            8'hF0:   w = W32_HI;
            default: w = W64;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snitch_tcdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snitch_tcdm_pkg
// Description : TCDM interconnect memory-side request/response types and
//               bank geometry.
// Revision    : 1.0  initial release
// ============================================================================
package snitch_tcdm_pkg;

    localparam int unsigned MemAddrWidth          = 10;
    localparam int unsigned DataWidth             = 64;
    localparam int unsigned StrbWidth             = DataWidth / 8;
    localparam int unsigned UserWidth             = 8;
    localparam int unsigned MemoryResponseLatency = 1;

    typedef logic [MemAddrWidth-1:0] mem_addr_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [StrbWidth-1:0]    strb_t;
    typedef logic [UserWidth-1:0]    user_t;

    typedef struct packed {
        mem_addr_t           addr;
        logic                write;
        reqrsp_pkg::amo_op_e amo;
        data_t               data;
        strb_t               strb;
        user_t               user;
    } mem_req_chan_t;

    typedef struct packed {
        logic          q_valid;
        mem_req_chan_t q;
    } mem_req_t;

    typedef struct packed {
        data_t data;
    } mem_rsp_chan_t;

    typedef struct packed {
        logic          q_ready;
        mem_rsp_chan_t p;
    } mem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/snitch_tcdm_amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : snitch_tcdm_amo_alu
// Description : Combinational atomic-operation ALU. Computes the new memory
//               word from the old word and the operand. 32-bit operations
//               leave the untouched half equal to the old word.
//               Compiled only when SNITCH_TCDM_BANK_AMO_EN is defined.
// Ports       : op_i      - atomic operation
//               width_i   - operand width / lane
//               old_i     - word currently in memory
//               operand_i - request data
//               result_o  - word to write back
// Revision    : 1.0  initial release
// ============================================================================
`ifdef SNITCH_TCDM_BANK_AMO_EN
module snitch_tcdm_amo_alu
    import snitch_tcdm_bank_pkg::*;
(
    input  reqrsp_pkg::amo_op_e op_i,
    input  amo_width_e          width_i,
    input  logic [63:0]         old_i,
    input  logic [63:0]         operand_i,
    output logic [63:0]         result_o
);

    logic        is_signed;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [64:0] a_ext;
    logic [64:0] b_ext;
    logic        a_lt_b;
    logic [63:0] r;

    always_comb begin
        is_signed = (op_i == reqrsp_pkg::AMOMax) || (op_i == reqrsp_pkg::AMOMin);
        a32       = (width_i == W32_HI) ? old_i[63:32]     : old_i[31:0];
        b32       = (width_i == W32_HI) ? operand_i[63:32] : operand_i[31:0];

        // One extra bit carries the sign (or a zero) so a single signed
        // comparator serves both signed and unsigned min/max.
        if (width_i == W64) begin
            a_ext = {is_signed & old_i[63],     old_i};
            b_ext = {is_signed & operand_i[63], operand_i};
        end else begin
            a_ext = {{33{is_signed & a32[31]}}, a32};
            b_ext = {{33{is_signed & b32[31]}}, b32};
        end
        a_lt_b = $signed(a_ext) < $signed(b_ext);

        case (op_i)
            reqrsp_pkg::AMOSwap: r = b_ext[63:0];
            reqrsp_pkg::AMOAdd:  r = a_ext[63:0] + b_ext[63:0];
            reqrsp_pkg::AMOAnd:  r = a_ext[63:0] & b_ext[63:0];
            reqrsp_pkg::AMOOr:   r = a_ext[63:0] | b_ext[63:0];
            reqrsp_pkg::AMOXor:  r = a_ext[63:0] ^ b_ext[63:0];
            reqrsp_pkg::AMOMax,
            reqrsp_pkg::AMOMaxu: r = a_lt_b ? b_ext[63:0] : a_ext[63:0];
            reqrsp_pkg::AMOMin,
            reqrsp_pkg::AMOMinu: r = a_lt_b ? a_ext[63:0] : b_ext[63:0];
            default:             r = a_ext[63:0];
        endcase

        case (width_i)
            W32_LO:  result_o = {old_i[63:32], r[31:0]};
            W32_HI:  result_o = {r[31:0], old_i[31:0]};
            default: result_o = r;
        endcase
    end

endmodule
`endif
`default_nettype wire

// File: rtl/snitch_tcdm_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : snitch_tcdm_mem_bank
// Description : Single-port TCDM memory bank with byte strobes, fixed
//               response latency and optional in-bank atomics.
//               Macro SNITCH_TCDM_BANK_AMO_EN enables the AMO FSM and ALU;
//               without it q_ready is tied high and q.amo is ignored.
// Ports       : clk_i     - clock
//               rst_ni    - asynchronous active-low reset
//               mem_req_i - request from the interconnect
//               mem_rsp_o - ready and response data
// Revision    : 1.0  initial release
// ============================================================================
module snitch_tcdm_mem_bank
    import snitch_tcdm_bank_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = snitch_tcdm_pkg::DataWidth,
    parameter int unsigned Latency   = snitch_tcdm_pkg::MemoryResponseLatency
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  snitch_tcdm_pkg::mem_req_t mem_req_i,
    output snitch_tcdm_pkg::mem_rsp_t mem_rsp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned AddrWidth = snitch_tcdm_pkg::MemAddrWidth;

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 req_fire;
    logic                 is_write;
    logic                 start_amo;
    logic                 q_ready;
    logic [DataWidth-1:0] rdata_q;
    logic [DataWidth-1:0] rdata_d;
    logic [DataWidth-1:0] rsp_data;

    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic [StrbWidth-1:0] wr_strb;
    logic [DataWidth-1:0] wr_word;

    logic unused_req_bits;

`ifdef SNITCH_TCDM_BANK_AMO_EN
    bank_state_e          state_q;
    logic                 ready_q;
    logic [DataWidth-1:0] amo_old_q;
    logic [DataWidth-1:0] amo_operand_q;
    reqrsp_pkg::amo_op_e  amo_op_q;
    logic [StrbWidth-1:0] amo_strb_q;
    logic [AddrWidth-1:0] amo_addr_q;
    logic [DataWidth-1:0] amo_result;

    assign unused_req_bits = ^mem_req_i.q.user;
    assign q_ready         = ready_q;

    // Request classification: LR reads, SC writes, an AMO with an unaligned
    // strobe degrades to a plain write.
    always_comb begin
        is_write  = mem_req_i.q.write;
        start_amo = 1'b0;
        case (mem_req_i.q.amo)
            reqrsp_pkg::AMONone: is_write = mem_req_i.q.write;
            reqrsp_pkg::AMOLR:   is_write = 1'b0;
            reqrsp_pkg::AMOSC:   is_write = 1'b1;
            default: begin
                if (strb_is_amo_width(mem_req_i.q.strb)) begin
                    start_amo = 1'b1;
                    is_write  = 1'b0;
                end else begin
                    is_write  = 1'b1;
                end
            end
        endcase
    end

    snitch_tcdm_amo_alu u_amo_alu (
        .op_i      (amo_op_q),
        .width_i   (strb_to_amo_width(amo_strb_q)),
        .old_i     (amo_old_q),
        .operand_i (amo_operand_q),
        .result_o  (amo_result)
    );

    // The async reset forces IDLE, so a pending AMO write is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            amo_old_q     <= '0;
            amo_operand_q <= '0;
            amo_op_q      <= reqrsp_pkg::AMONone;
            amo_strb_q    <= '0;
            amo_addr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire && start_amo) begin
                        state_q       <= AMO_WR;
                        ready_q       <= 1'b0;
                        amo_old_q     <= mem_q[mem_req_i.q.addr];
                        amo_operand_q <= mem_req_i.q.data;
                        amo_op_q      <= mem_req_i.q.amo;
                        amo_strb_q    <= mem_req_i.q.strb;
                        amo_addr_q    <= mem_req_i.q.addr;
                    end
                end
                AMO_WR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign unused_req_bits = ^{mem_req_i.q.user, mem_req_i.q.amo};
    assign q_ready         = 1'b1;
    assign is_write        = mem_req_i.q.write;
    assign start_amo       = 1'b0;
`endif

    assign req_fire = mem_req_i.q_valid & q_ready;

    // Single write port shared by plain writes and the AMO write-back.
    always_comb begin
        wr_en   = req_fire & is_write;
        wr_addr = mem_req_i.q.addr;
        wr_data = mem_req_i.q.data;
        wr_strb = mem_req_i.q.strb;
`ifdef SNITCH_TCDM_BANK_AMO_EN
        if (state_q == AMO_WR) begin
            wr_en   = 1'b1;
            wr_addr = amo_addr_q;
            wr_data = amo_result;
            wr_strb = amo_strb_q;
        end
`endif
        wr_word = mem_q[wr_addr];
        for (int b = 0; b < int'(StrbWidth); b++) begin
            if (wr_strb[b]) begin
                wr_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // Writes and SC respond with zero; reads and AMOs with the old word.
    assign rdata_d = is_write ? '0 : mem_q[mem_req_i.q.addr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (req_fire) begin
            rdata_q <= rdata_d;
        end
    end

    generate
        if (Latency > 1) begin : g_rsp_pipe
            logic [Latency-2:0][DataWidth-1:0] stage_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= rdata_q;
                    for (int i = 1; i < int'(Latency) - 1; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign rsp_data = stage_q[Latency-2];
        end else begin : g_rsp_direct
            assign rsp_data = rdata_q;
        end
    endgenerate

    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = q_ready;
        mem_rsp_o.p.data  = rsp_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_snitch_tcdm_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_snitch_tcdm_mem_bank
// Description : Self-checking bench for snitch_tcdm_mem_bank. Drives a
//               Latency=1 and a Latency=3 instance with the same requests
//               and compares both against a behavioural memory model.
//               AMO sequences are built when SNITCH_TCDM_BANK_AMO_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module tb_snitch_tcdm_mem_bank;
    import snitch_tcdm_pkg::*;
    import reqrsp_pkg::*;

    logic     clk   = 1'b0;
    logic     rst_n = 1'b1;
    mem_req_t req;
    mem_rsp_t rsp1;
    mem_rsp_t rsp3;

    always #5 clk = ~clk;

    snitch_tcdm_mem_bank u_dut1 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mem_req_i (req),
        .mem_rsp_o (rsp1)
    );

    snitch_tcdm_mem_bank #(.Latency(3)) u_dut3 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mem_req_i (req),
        .mem_rsp_o (rsp3)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mem [16];
    logic [63:0] m_p1;
    logic [63:0] m_hist [3];   // m_hist[k]: latency-1 response k edges ago
    bit          m_busy;
    int          m_paddr;
    logic [63:0] m_pword;

    function automatic logic [63:0] ref_amo(input amo_op_e op, input logic [7:0] strb,
                                            input logic [63:0] old, input logic [63:0] opd);
        longint          so, sd;
        longint unsigned uo, ud, r, mask;
        int              sh;
        bit              w32;
        w32 = (strb != 8'hFF);
        sh  = (strb == 8'hF0) ? 32 : 0;
        if (w32) begin
            uo = (old >> sh) & 64'hFFFF_FFFF;
            ud = (opd >> sh) & 64'hFFFF_FFFF;
            so = longint'(int'(uo[31:0]));
            sd = longint'(int'(ud[31:0]));
        end else begin
            uo = old; ud = opd;
            so = longint'(old); sd = longint'(opd);
        end
        case (op)
            AMOSwap: r = ud;
            AMOAdd:  r = uo + ud;
            AMOAnd:  r = uo & ud;
            AMOOr:   r = uo | ud;
            AMOXor:  r = uo ^ ud;
            AMOMax:  r = (so > sd) ? uo : ud;
            AMOMin:  r = (so < sd) ? uo : ud;
            AMOMaxu: r = (uo > ud) ? uo : ud;
            AMOMinu: r = (uo < ud) ? uo : ud;
            default: r = uo;
        endcase
        if (!w32) return r;
        mask = 64'hFFFF_FFFF << sh;
        return (old & ~mask) | ((r << sh) & mask);
    endfunction

    task automatic model_reset();
        m_p1 = '0;
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
        m_busy = 0;
    endtask

    task automatic model_edge();
        int a;
        int kind;   // 0 read, 1 write, 2 atomic
        a = int'(req.q.addr);
        if (m_busy) begin
            m_mem[m_paddr] = m_pword;
            m_busy = 0;
        end else if (req.q_valid) begin
`ifdef SNITCH_TCDM_BANK_AMO_EN
            if (req.q.amo == AMONone)   kind = req.q.write ? 1 : 0;
            else if (req.q.amo == AMOLR) kind = 0;
            else if (req.q.amo == AMOSC) kind = 1;
            else if (req.q.strb == 8'h0F || req.q.strb == 8'hF0 || req.q.strb == 8'hFF) kind = 2;
            else kind = 1;
`else
            kind = req.q.write ? 1 : 0;
`endif
            if (kind == 0) begin
                m_p1 = m_mem[a];
            end else if (kind == 1) begin
                m_p1 = '0;
                for (int b = 0; b < 8; b++)
                    if (req.q.strb[b]) m_mem[a][8*b +: 8] = req.q.data[8*b +: 8];
            end else begin
                m_p1    = m_mem[a];
                m_pword = ref_amo(req.q.amo, req.q.strb, m_mem[a], req.q.data);
                m_paddr = a;
                m_busy  = 1;
            end
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = m_p1;
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check("model rdy L1",  rsp1.q_ready, !m_busy);
        check("model rdy L3",  rsp3.q_ready, !m_busy);
        check("model data L1", rsp1.p.data, m_p1);
        check("model data L3", rsp3.p.data, m_hist[2]);
    endtask

    task automatic set_req(input logic v, input int addr, input logic wr, input amo_op_e op,
                           input logic [63:0] data, input logic [7:0] strb);
        req.q_valid = v;
        req.q.addr  = addr[9:0];
        req.q.write = wr;
        req.q.amo   = op;
        req.q.data  = data;
        req.q.strb  = strb;
        req.q.user  = 8'($urandom);
    endtask

    typedef struct {
        logic        v;
        int          addr;
        logic        wr;
        amo_op_e     op;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;   // latency-1 p.data after the edge
    } vec_t;

    vec_t        tbl [14];
    logic [63:0] obs [6];

    initial begin
        tbl[0]  = '{1'b1, 5, 1'b1, AMONone, 64'h1122_3344_5566_7788, 8'hFF, 64'h0};
        tbl[1]  = '{1'b1, 5, 1'b0, AMONone, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
        tbl[2]  = '{1'b1, 7, 1'b1, AMONone, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
        tbl[3]  = '{1'b1, 7, 1'b1, AMONone, 64'h0, 8'h0F, 64'h0};
        tbl[4]  = '{1'b1, 7, 1'b0, AMONone, 64'h0, 8'h00, 64'hFFFF_FFFF_0000_0000};
        tbl[5]  = '{1'b1, 4, 1'b1, AMONone, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 64'h0};
        tbl[6]  = '{1'b1, 4, 1'b1, AMONone, 64'h0123_4567_89AB_CDEF, 8'h3C, 64'h0};
        tbl[7]  = '{1'b1, 4, 1'b0, AMONone, 64'h0, 8'h00, 64'hA5A5_4567_89AB_A5A5};
        tbl[8]  = '{1'b0, 4, 1'b0, AMONone, 64'h0, 8'h00, 64'hA5A5_4567_89AB_A5A5};
        tbl[9]  = '{1'b0, 5, 1'b1, AMONone, 64'h0, 8'hFF, 64'hA5A5_4567_89AB_A5A5};
        tbl[10] = '{1'b1, 5, 1'b0, AMONone, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
        tbl[11] = '{1'b1, 5, 1'b0, AMOLR,   64'h0, 8'hFF, 64'h1122_3344_5566_7788};
        tbl[12] = '{1'b1, 5, 1'b1, AMONone, 64'h0, 8'h00, 64'h0};
        tbl[13] = '{1'b1, 5, 1'b0, AMONone, 64'h0, 8'h00, 64'h1122_3344_5566_7788};

        req = '0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset rdy",  rsp1.q_ready, 1'b1);
        check("reset data", rsp1.p.data, 64'h0);
        check("reset L3",   rsp3.p.data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload words 0..15; word 9 holds 0xAA for the reset-in-AMO case.
        for (int a = 0; a < 16; a++) begin
            set_req(1'b1, a, 1'b1, AMONone, (a == 9) ? 64'hAA : 64'(a), 8'hFF);
            tick();
        end

        // Latency=3: four back-to-back reads, data appears two edges later.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_req(1'b1, c, 1'b0, AMONone, 64'h0, 8'h00);
            else       set_req(1'b0, 0, 1'b0, AMONone, 64'h0, 8'h00);
            tick();
            obs[c] = rsp3.p.data;
        end
        for (int c = 2; c < 6; c++) check("L3 read seq", obs[c], 64'(c - 2));

        for (int i = 0; i < 14; i++) begin
            set_req(tbl[i].v, tbl[i].addr, tbl[i].wr, tbl[i].op, tbl[i].data, tbl[i].strb);
            tick();
            check("table", rsp1.p.data, tbl[i].exp);
        end

`ifdef SNITCH_TCDM_BANK_AMO_EN
        // 64-bit add with the next request held valid.
        set_req(1'b1, 3, 1'b1, AMONone, 64'd10, 8'hFF); tick();
        set_req(1'b1, 3, 1'b0, AMOAdd, 64'd5, 8'hFF); tick();
        check("amoadd busy", rsp1.q_ready, 1'b0);
        check("amoadd old",  rsp1.p.data, 64'd10);
        set_req(1'b1, 3, 1'b0, AMONone, 64'h0, 8'h00); tick();
        check("amoadd ready", rsp1.q_ready, 1'b1);
        tick();
        check("amoadd result", rsp1.p.data, 64'd15);

        // Signed 32-bit max on the upper half.
        set_req(1'b1, 2, 1'b1, AMONone, 64'h8000_0000_0000_0001, 8'hFF); tick();
        set_req(1'b1, 2, 1'b0, AMOMax, 64'h0000_0001_0000_0000, 8'hF0); tick();
        check("amomax old", rsp1.p.data, 64'h8000_0000_0000_0001);
        set_req(1'b0, 2, 1'b0, AMONone, 64'h0, 8'h00); tick();
        set_req(1'b1, 2, 1'b0, AMONone, 64'h0, 8'h00); tick();
        check("amomax result", rsp1.p.data, 64'h0000_0001_0000_0001);

        // Reset pulse during AMO_WR drops the swap write.
        set_req(1'b1, 9, 1'b0, AMOSwap, 64'h55, 8'hFF); tick();
        check("swap busy", rsp1.q_ready, 1'b0);
        set_req(1'b0, 9, 1'b0, AMONone, 64'h0, 8'h00);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst mid rdy",  rsp1.q_ready, 1'b1);
        check("rst mid data", rsp1.p.data, 64'h0);
        rst_n = 1'b1;
        tick();
        set_req(1'b1, 9, 1'b0, AMONone, 64'h0, 8'h00); tick();
        check("rst mid mem", rsp1.p.data, 64'hAA);
`else
        // Without atomics q.amo is ignored: an AMOAdd read is a plain read.
        set_req(1'b1, 3, 1'b0, AMOAdd, 64'd5, 8'hFF); tick();
        check("noamo ready", rsp1.q_ready, 1'b1);
        check("noamo read",  rsp1.p.data, 64'd3);
        set_req(1'b1, 3, 1'b0, AMONone, 64'h0, 8'h00); tick();
        check("noamo unchanged", rsp1.p.data, 64'd3);
        set_req(1'b1, 3, 1'b1, AMOSwap, 64'h77, 8'hFF); tick();
        set_req(1'b1, 3, 1'b0, AMONone, 64'h0, 8'h00); tick();
        check("noamo write", rsp1.p.data, 64'h77);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] s;
            amo_op_e    op;
            case ($urandom_range(0, 3))
                0:       s = 8'hFF;
                1:       s = 8'h0F;
                2:       s = 8'hF0;
                default: s = 8'($urandom);
            endcase
            op = ($urandom_range(0, 1) == 0) ? AMONone : amo_op_e'(4'($urandom_range(1, 11)));
            set_req($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 1'($urandom),
                    op, {$urandom, $urandom}, s);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snitch_tcdm_mem_bank.md
# snitch_tcdm_mem_bank

Single-port TCDM memory bank that consumes one `mem_req_t` output of `snitch_tcdm_interconnect` and returns the matching `mem_rsp_t`. It sits directly downstream of the interconnect, one instance per output port, and serves as the behavioural bank for block-level benches and small SNAX test clusters. It provides byte-strobed reads and writes with a fixed response latency, plus optional in-bank atomic memory operations.

## Interface

**Parameters**
- `NumWords`, default `1024`: bank depth in `DataWidth` words; must equal `2**snitch_tcdm_pkg::MemAddrWidth`.
- `DataWidth`, default `snitch_tcdm_pkg::DataWidth` (64): word width; must be 64.
- `Latency`, default `snitch_tcdm_pkg::MemoryResponseLatency` (1): cycles from request acceptance to valid `p.data`; legal range 1..4.

**Ports**
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `mem_req_i`, in, `snitch_tcdm_pkg::mem_req_t`: fields `q_valid`, `q.addr`, `q.write`, `q.amo`, `q.data`, `q.strb`, `q.user`.
- `mem_rsp_o`, out, `snitch_tcdm_pkg::mem_rsp_t`: fields `q_ready` and `p.data`.

## Operation

- **Accept.** A request is accepted on a cycle where `q_valid && q_ready`. `q.addr` is a word index and is not byte-shifted.
- **Read** (`write=0`, `amo=AMONone`):
  - `p.data` carries the word at `addr` as it stood at the acceptance edge.
  - A write accepted in cycle t is visible to a read accepted in t+1.
- **Write** (`write=1`, `amo=AMONone`):
  - Bytes with `strb[i]=1` are updated at the acceptance edge; all other bytes are kept.
  - `p.data` returns `'0`.
- **`q.user`** is ignored by the bank.
- **`q_ready`** is `1` in IDLE and `0` in AMO_WR. A request that is not accepted has no effect on the bank.
- **State machine** (only with AMO enabled; see Configuration):
  - IDLE → AMO_WR: on acceptance of `amo ∉ {AMONone, AMOLR, AMOSC}`. At that edge, the old word is latched into `amo_old_q`, and the operand (`q.data`), op, strb and addr are latched.
  - AMO_WR → IDLE: unconditionally after one cycle. In this cycle the bank writes `alu(amo_old_q, operand)` under the latched strb.
- **AMO width, selected by latched strb:**
  - `0x0F`: 32-bit op on bits [31:0].
  - `0xF0`: 32-bit op on bits [63:32].
  - `0xFF`: 64-bit op.
  - Any other strb: the request degrades to a plain write and the bank does not enter AMO_WR.
- **Supported AMOs:** Swap, Add (wrapping), And, Or, Xor, Max, Min (signed), Maxu, Minu (unsigned).
- **AMO response:** `p.data` returns the full old 64-bit word.
- **LR and SC:** `AMOLR` is a plain read. `AMOSC` is a plain write that returns `'0`.

## Timing

- **Response latency.** `p.data` for a request accepted at edge t is valid during cycle t+Latency and is held until overwritten by the next response.
  - `Latency=1`: `p.data` comes from the array read register.
  - `Latency>1`: the response passes through `Latency-1` extra register stages.
- **Throughput.** One plain request per cycle. An AMO occupies 2 cycles (acceptance plus AMO_WR), and the next request is accepted no earlier than t+2.
- **AMO write visibility.** The AMO write lands at the end of the AMO_WR cycle, so a read accepted at t+2 sees the AMO result.
- **Reset values.**
  - State is IDLE, so `q_ready=1` during and after reset.
  - `p.data='0`; all pipeline stages are `'0`.
  - Array contents are not reset.
- **Reset asserted mid-AMO** (in AMO_WR): the pending write is dropped, memory holds the old word, and state returns to IDLE.
- **`q_valid=0`:** no array access occurs. `p.data` still advances through the pipeline, holding its last value.

## Configuration

- Macro: `SNITCH_TCDM_BANK_AMO_EN`.
- **Defined:** AMO FSM, latches and `snitch_tcdm_amo_alu` are compiled in, with behaviour as above.
- **Undefined:**
  - No FSM; `q_ready` is tied to `1`.
  - `q.amo` is ignored and every request is treated as a plain read or write according to `q.write`.
  - Every cycle accepts a request.

## Structure

- **Shared package `snitch_tcdm_bank_pkg`:**
  - `bank_state_e` (IDLE, AMO_WR).
  - `amo_width_e` (W32_LO, W32_HI, W64).
  - Function `strb_to_amo_width`.
  - `MaxLatency = 4`.
- **Reused types:** `mem_req_t`, `mem_rsp_t` and `reqrsp_pkg::amo_op_e` are reused from their existing packages, not redefined.
- **Sub-module `snitch_tcdm_amo_alu`:** purely combinational. Inputs are `op`, `width`, `old`, `operand`; output is the 64-bit `result`. Half-word ops leave the other 32 bits equal to `old`.

## Test plan

- **Write/read:** write `addr=5`, `data=0x1122_3344_5566_7788`, `strb=0xFF`, then read `addr=5` → `p.data=0x1122334455667788` one cycle after read acceptance (`Latency=1`).
- **Partial strobe:** preload `addr=7` with `0xFFFF_FFFF_FFFF_FFFF`, write `data=0`, `strb=0x0F` → read returns `0xFFFF_FFFF_0000_0000`.
- **64-bit AMO add:** preload `addr=3` with `10`, then `AMOAdd`, `data=5`, `strb=0xFF`, followed by back-to-back `q_valid` → `q_ready=0` in the cycle after acceptance, `p.data=10`, and a subsequent read returns `15`.
- **Signed 32-bit max on upper half:** preload `addr=2` with `0x8000_0000_0000_0001`, then `AMOMax`, `data=0x0000_0001_0000_0000`, `strb=0xF0` → word becomes `0x0000_0001_0000_0001`.
- **Reset in AMO_WR:** `AMOSwap` on `addr=9` (old `0xAA`) with `rst_ni` pulsed low during AMO_WR → after reset `q_ready=1`, `p.data=0`, and a read of `addr=9` returns `0xAA`.
- **`Latency=3`:** 4 consecutive reads of addresses 0..3 preloaded with 0..3 → `p.data` shows 0,1,2,3 on cycles t+3..t+6.
